// File: rtl/shunt_clk_sched_pkg.sv
// rtl/shunt_clk_sched_pkg.sv - shared types and helpers for the mission clock scheduler
package shunt_clk_sched_pkg;

    localparam int SCHED_NUM_CLOCKS = 4;
    localparam int SCHED_DATA_W     = 9;
    localparam int SCHED_ID_W       = $clog2(SCHED_NUM_CLOCKS);

    typedef enum logic [1:0] {
        IDLE,
        PUT,
        STRETCH
    } sched_state_t;

    typedef struct packed {
        logic [SCHED_ID_W-1:0]   id;
        logic [SCHED_DATA_W-1:0] data;
    } put_req_t;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic int lowest_set(input logic [31:0] mask);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/shunt_clk_edge_det.sv
// rtl/shunt_clk_edge_det.sv - mission clock rising-edge detector with hold
// While sampling is disabled the previous level is held, so edges during a freeze surface once sampling resumes.
module shunt_clk_edge_det #(
    parameter int NUM_CLOCKS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sample_en,
    input  logic [NUM_CLOCKS-1:0] mclk,
    output logic [NUM_CLOCKS-1:0] rise
);

    logic [NUM_CLOCKS-1:0] mclk_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mclk_d <= '0;
        end else if (sample_en) begin
            mclk_d <= mclk;
        end
    end

    assign rise = sample_en ? (mclk & ~mclk_d) : '0;

endmodule

// File: rtl/shunt_clk_sched.sv
// rtl/shunt_clk_sched.sv - freezes mission clocks on an edge and sequences one put per arrived clock
// Puts go out lowest index first; a watchdog drops a slot that is never accepted.
module shunt_clk_sched
    import shunt_clk_sched_pkg::*;
#(
    parameter int NUM_CLOCKS     = SCHED_NUM_CLOCKS,
    parameter int DATA_W         = SCHED_DATA_W,
    parameter int FREEZE_STRETCH = 2,
    parameter int WDOG_CYC       = 1000,
    parameter int ID_W           = $clog2(NUM_CLOCKS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CLOCKS-1:0]        mclk_i,
    input  logic [NUM_CLOCKS*DATA_W-1:0] slot_data_i,
    output logic [NUM_CLOCKS-1:0]        freeze_clk_o,
    output logic                         put_valid_o,
    output logic [ID_W-1:0]              put_id_o,
    output logic [DATA_W-1:0]            put_data_o,
    input  logic                         put_ready_i,
    output logic                         busy_o,
    output logic                         err_o,
    output logic [15:0]                  round_cnt_o
);

    localparam int SW = (FREEZE_STRETCH > 0) ? $clog2(FREEZE_STRETCH + 1) : 1;
    localparam int WW = $clog2(WDOG_CYC + 1);

    sched_state_t          state_q, state_d;
    logic [NUM_CLOCKS-1:0] pending_q, pending_d;
    logic [DATA_W-1:0]     cap_q [NUM_CLOCKS];
    logic [SW-1:0]         stretch_q, stretch_d;
    logic [WW-1:0]         wdog_q, wdog_d;
    logic                  err_q, set_err;
    logic [15:0]           round_q;
    logic                  round_inc;
    logic [NUM_CLOCKS-1:0] rise;
    logic [NUM_CLOCKS-1:0] cur_mask;
    logic                  slot_done;
    put_req_t              cur;

    shunt_clk_edge_det #(
        .NUM_CLOCKS(NUM_CLOCKS)
    ) u_edge_det (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .sample_en(state_q == IDLE),
        .mclk     (mclk_i),
        .rise     (rise)
    );

    always_comb begin
        cur.id   = ID_W'(lowest_set(32'(pending_q)));
        cur.data = cap_q[cur.id];
        cur_mask = NUM_CLOCKS'(1) << cur.id;
    end

    assign put_valid_o  = (state_q == PUT);
    assign put_id_o     = put_valid_o ? cur.id : '0;
    assign put_data_o   = put_valid_o ? cur.data : '0;
    assign freeze_clk_o = {NUM_CLOCKS{state_q != IDLE}};
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;
    assign round_cnt_o  = round_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= '0;
            stretch_q <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            round_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            stretch_q <= stretch_d;
            wdog_q    <= wdog_d;
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (round_inc) begin
                round_q <= round_q + 16'd1;
            end
        end
    end

    // rise is only non-zero in IDLE, so captures never disturb a round in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_CLOCKS; k++) begin
                cap_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CLOCKS; k++) begin
                if (rise[k]) begin
                    cap_q[k] <= slot_data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        stretch_d = stretch_q;
        wdog_d    = wdog_q;
        set_err   = 1'b0;
        round_inc = 1'b0;
        slot_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (|rise) begin
                    pending_d = rise;
                    wdog_d    = '0;
                    state_d   = PUT;
                end
            end
            PUT: begin
                slot_done = put_ready_i || (wdog_q == WW'(WDOG_CYC - 1));
                if (slot_done) begin
                    set_err   = !put_ready_i;
                    pending_d = pending_q & ~cur_mask;
                    wdog_d    = '0;
                    if (pending_d == '0) begin
                        if (FREEZE_STRETCH == 0) begin
                            state_d   = IDLE;
                            round_inc = 1'b1;
                        end else begin
                            state_d   = STRETCH;
                            stretch_d = SW'(FREEZE_STRETCH);
                        end
                    end
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            STRETCH: begin
                // Freeze stays up for exactly FREEZE_STRETCH cycles after the last put.
                if (stretch_q <= SW'(1)) begin
                    state_d   = IDLE;
                    round_inc = 1'b1;
                end else begin
                    stretch_d = stretch_q - SW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
